// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arb_pkg
//  Description : Shared types and constants for the data-memory port arbiter:
//                arbiter state encoding, default bus widths, and the width of
//                the size/sign mask carried with every access.
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_arb_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int MASK_W     = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CPU_ACC = 2'd1,
        ST_AUX_ACC = 2'd2
    } arb_state_e;

endpackage : dmem_arb_pkg
`default_nettype wire

// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_port_arbiter
//  Description : Shares one data-memory port between the CPU and an auxiliary
//                master (loader / debug DMA). Each access is a multi-cycle
//                transaction that honours data_mem's busy output, and the CPU
//                clock-stall is generated here.
//  Ports       : clk, rst_n               - clock, async active-low reset
//                cpu_*                    - CPU load/store request and response
//                aux_valid/write/addr/... - aux request (held until aux_ready)
//                aux_ready/done/rdata     - aux accept, completion, read data
//                mem_*                    - data_mem request and response
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int MAX_AUX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_memwrite,
    input  logic              cpu_memread,
    input  logic [MASK_W-1:0] cpu_sign_mask,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              aux_valid,
    input  logic              aux_write,
    input  logic [ADDR_W-1:0] aux_addr,
    input  logic [DATA_W-1:0] aux_wdata,
    input  logic [MASK_W-1:0] aux_sign_mask,
    output logic              aux_ready,
    output logic              aux_done,
    output logic [DATA_W-1:0] aux_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_memwrite,
    output logic              mem_memread,
    output logic [MASK_W-1:0] mem_sign_mask,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_busy
);

    localparam logic [3:0] MAX_WAIT = 4'(MAX_AUX_WAIT);

    arb_state_e        state_q, state_d;
    logic [3:0]        count_q, count_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              re_q, re_d;
    logic [MASK_W-1:0] mask_q, mask_d;
    logic              aux_done_q, aux_done_d;
    logic [DATA_W-1:0] aux_rdata_q, aux_rdata_d;
    logic              grant_aux;

    wire cpu_req  = cpu_memread | cpu_memwrite;
    wire cpu_done = (state_q == ST_CPU_ACC) && !mem_busy;
    wire in_acc   = (state_q != ST_IDLE);

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        re_d        = re_q;
        mask_d      = mask_q;
        aux_done_d  = 1'b0;
        aux_rdata_d = aux_rdata_q;
        grant_aux   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // CPU wins unless aux has already lost MAX_AUX_WAIT contests.
                if (cpu_req && (!aux_valid || (count_q < MAX_WAIT))) begin
                    state_d = ST_CPU_ACC;
                    addr_d  = cpu_addr;
                    wdata_d = cpu_wdata;
                    we_d    = cpu_memwrite;
                    re_d    = cpu_memread;
                    mask_d  = cpu_sign_mask;
                    if (aux_valid) begin
                        count_d = count_q + 4'd1;
                    end
                end else if (aux_valid) begin
                    state_d   = ST_AUX_ACC;
                    addr_d    = aux_addr;
                    wdata_d   = aux_wdata;
                    we_d      = aux_write;
                    re_d      = !aux_write;
                    mask_d    = aux_sign_mask;
                    count_d   = 4'd0;
                    grant_aux = 1'b1;
                end
            end
            ST_CPU_ACC: begin
                if (!mem_busy) begin
                    state_d = ST_IDLE;
                end
            end
            ST_AUX_ACC: begin
                if (!mem_busy) begin
                    state_d    = ST_IDLE;
                    aux_done_d = 1'b1;
                    if (re_q) begin
                        aux_rdata_d = mem_rdata;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            count_q     <= 4'd0;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            re_q        <= 1'b0;
            mask_q      <= '0;
            aux_done_q  <= 1'b0;
            aux_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            re_q        <= re_d;
            mask_q      <= mask_d;
            aux_done_q  <= aux_done_d;
            aux_rdata_q <= aux_rdata_d;
        end
    end

    // Strobes are qualified by the state so an async reset kills them at once.
    assign mem_addr      = addr_q;
    assign mem_wdata     = wdata_q;
    assign mem_sign_mask = mask_q;
    assign mem_memwrite  = in_acc & we_q;
    assign mem_memread   = in_acc & re_q;

    // The CPU clock is held while reset is asserted or its access is pending.
    assign cpu_stall = !rst_n || (cpu_req && !cpu_done);
    assign cpu_rdata = cpu_done ? mem_rdata : '0;

    assign aux_ready = grant_aux & rst_n;
    assign aux_done  = aux_done_q;
    assign aux_rdata = aux_rdata_q;

endmodule : dmem_port_arbiter
`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_port_arbiter
//  Description : Directed self-checking bench for dmem_port_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_memwrite, cpu_memread, cpu_stall;
    logic [3:0]  cpu_sign_mask;
    logic        aux_valid, aux_write, aux_ready, aux_done;
    logic [31:0] aux_addr, aux_wdata, aux_rdata;
    logic [3:0]  aux_sign_mask;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_memwrite, mem_memread, mem_busy;
    logic [3:0]  mem_sign_mask;

    int n_assert = 0;
    int n_fail   = 0;

    logic [15:0] seq;
    int          got;
    int          wr_cnt, st_cnt;

    always #5 clk = ~clk;

    dmem_port_arbiter #(
        .ADDR_W       (32),
        .DATA_W       (32),
        .MAX_AUX_WAIT (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cpu_addr      (cpu_addr),
        .cpu_wdata     (cpu_wdata),
        .cpu_memwrite  (cpu_memwrite),
        .cpu_memread   (cpu_memread),
        .cpu_sign_mask (cpu_sign_mask),
        .cpu_rdata     (cpu_rdata),
        .cpu_stall     (cpu_stall),
        .aux_valid     (aux_valid),
        .aux_write     (aux_write),
        .aux_addr      (aux_addr),
        .aux_wdata     (aux_wdata),
        .aux_sign_mask (aux_sign_mask),
        .aux_ready     (aux_ready),
        .aux_done      (aux_done),
        .aux_rdata     (aux_rdata),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_memwrite  (mem_memwrite),
        .mem_memread   (mem_memread),
        .mem_sign_mask (mem_sign_mask),
        .mem_rdata     (mem_rdata),
        .mem_busy      (mem_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // CPU and aux both request continuously; record who owns each access
    // (1 = aux, 0 = CPU), first grant in the most significant used bit.
    task automatic run_contested(input int n, output logic [15:0] s, output int g);
        cpu_memread  = 1'b1;
        cpu_memwrite = 1'b0;
        cpu_addr     = 32'h0000_0100;
        aux_valid    = 1'b1;
        aux_write    = 1'b0;
        aux_addr     = 32'h0000_0200;
        mem_busy     = 1'b0;
        s = '0;
        g = 0;
        for (int c = 0; c < 200 && g < n; c++) begin
            @(negedge clk);
            #1;
            if (mem_memread || mem_memwrite) begin
                s = {s[14:0], (mem_addr == 32'h0000_0200)};
                g++;
            end
        end
        cpu_memread = 1'b0;
        aux_valid   = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        cpu_addr = '0; cpu_wdata = '0; cpu_memwrite = 1'b0; cpu_memread = 1'b0;
        cpu_sign_mask = '0;
        aux_valid = 1'b0; aux_write = 1'b0; aux_addr = '0; aux_wdata = '0;
        aux_sign_mask = '0;
        mem_rdata = '0; mem_busy = 1'b0;

        // Reset state
        @(negedge clk); #1;
        check("rst_cpu_stall", cpu_stall, 1);
        check("rst_memread", mem_memread, 0);
        check("rst_memwrite", mem_memwrite, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_aux_ready", aux_ready, 0);
        check("rst_aux_done", aux_done, 0);
        check("rst_aux_rdata", aux_rdata, 0);
        check("rst_cpu_rdata", cpu_rdata, 0);
        @(negedge clk); rst_n = 1'b1; #1;
        check("idle_cpu_stall", cpu_stall, 0);

        // CPU load, single-cycle access
        @(negedge clk);
        cpu_memread = 1'b1; cpu_addr = 32'h0000_1000; cpu_sign_mask = 4'hF;
        mem_rdata = 32'hDEAD_BEEF; mem_busy = 1'b0; #1;
        check("ld_idle_stall", cpu_stall, 1);
        check("ld_idle_memread", mem_memread, 0);
        check("ld_idle_cpu_rdata", cpu_rdata, 0);
        @(negedge clk); #1;
        check("ld_acc_memread", mem_memread, 1);
        check("ld_acc_addr", mem_addr, 32'h0000_1000);
        check("ld_acc_mask", mem_sign_mask, 4'hF);
        check("ld_acc_stall", cpu_stall, 0);
        check("ld_acc_cpu_rdata", cpu_rdata, 32'hDEAD_BEEF);
        cpu_memread = 1'b0;
        @(negedge clk); #1;
        check("ld_post_memread", mem_memread, 0);
        check("ld_post_cpu_rdata", cpu_rdata, 0);

        // CPU store, busy for 3 cycles inside the access
        @(negedge clk);
        cpu_memwrite = 1'b1; cpu_addr = 32'h0000_1010; cpu_wdata = 32'hA5A5_A5A5;
        wr_cnt = 0; st_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge clk);
            mem_busy = (k < 4);
            #1;
            if (mem_memwrite) wr_cnt++;
            if (cpu_stall) st_cnt++;
            if (k == 1) check("st_wdata", mem_wdata, 32'hA5A5_A5A5);
            if (k == 4) cpu_memwrite = 1'b0;
        end
        check("st_memwrite_cycles", wr_cnt, 4);
        check("st_stall_cycles", st_cnt, 4);
        check("st_post_memwrite", mem_memwrite, 0);
        mem_busy = 1'b0;

        // Aux read with the CPU idle
        @(negedge clk);
        aux_valid = 1'b1; aux_write = 1'b0; aux_addr = 32'h0000_2004;
        aux_sign_mask = 4'h3; mem_rdata = 32'h1234_5678; #1;
        check("ar_ready", aux_ready, 1);
        check("ar_idle_memread", mem_memread, 0);
        @(negedge clk); aux_valid = 1'b0; #1;
        check("ar_acc_ready", aux_ready, 0);
        check("ar_acc_memread", mem_memread, 1);
        check("ar_acc_addr", mem_addr, 32'h0000_2004);
        check("ar_acc_mask", mem_sign_mask, 4'h3);
        check("ar_acc_done", aux_done, 0);
        check("ar_acc_cpu_stall", cpu_stall, 0);
        check("ar_acc_cpu_rdata", cpu_rdata, 0);
        @(negedge clk); mem_rdata = 32'hCAFE_0000; #1;
        check("ar_done", aux_done, 1);
        check("ar_rdata", aux_rdata, 32'h1234_5678);
        @(negedge clk); #1;
        check("ar_done_pulse", aux_done, 0);
        check("ar_rdata_hold", aux_rdata, 32'h1234_5678);

        // Aux write leaves aux_rdata untouched
        @(negedge clk);
        aux_valid = 1'b1; aux_write = 1'b1; aux_addr = 32'h0000_2008;
        aux_wdata = 32'h0BAD_F00D; mem_rdata = 32'h5555_5555; #1;
        check("aw_ready", aux_ready, 1);
        @(negedge clk); aux_valid = 1'b0; #1;
        check("aw_memwrite", mem_memwrite, 1);
        check("aw_memread", mem_memread, 0);
        check("aw_wdata", mem_wdata, 32'h0BAD_F00D);
        @(negedge clk); #1;
        check("aw_done", aux_done, 1);
        check("aw_rdata_keep", aux_rdata, 32'h1234_5678);

        // Contested grants: C,C,C,C,A,C,C,C,C,A,C,C (ends with count = 2)
        @(negedge clk);
        run_contested(12, seq, got);
        check("cont_grants", got, 12);
        check("cont_seq", seq, 16'b0000_0000_1000_0100);

        // Reset in IDLE must clear the starvation count
        @(negedge clk); #1;
        rst_n = 1'b0; #1;
        check("rst2_aux_rdata", aux_rdata, 0);
        check("rst2_cpu_stall", cpu_stall, 1);
        @(negedge clk); rst_n = 1'b1;
        run_contested(5, seq, got);
        check("cont2_grants", got, 5);
        check("cont2_seq", seq, 16'b0000_0000_0000_0001);

        // Reset in the middle of a stalled aux access
        @(negedge clk); #1;
        aux_valid = 1'b1; aux_write = 1'b0; aux_addr = 32'h0000_2004; mem_busy = 1'b1; #1;
        check("ra_ready", aux_ready, 1);
        @(negedge clk); aux_valid = 1'b0; #1;
        check("ra_acc_memread", mem_memread, 1);
        #1 rst_n = 1'b0; #1;
        check("ra_rst_memread", mem_memread, 0);
        check("ra_rst_memwrite", mem_memwrite, 0);
        check("ra_rst_addr", mem_addr, 0);
        check("ra_rst_stall", cpu_stall, 1);
        @(negedge clk); #1;
        check("ra_rst_done", aux_done, 0);
        @(negedge clk); rst_n = 1'b1; mem_busy = 1'b0; #1;
        check("ra_rel_done", aux_done, 0);
        check("ra_rel_memread", mem_memread, 0);
        check("ra_rel_stall", cpu_stall, 0);
        @(negedge clk); #1;
        check("ra_post_done", aux_done, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_dmem_port_arbiter
`default_nettype wire
